mem_rd_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 49 ++++
 rtl/rd_order_fifo.sv | 73 +++++++
 rtl/mem_rd_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_rd_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the 2:1 AXI4 read-channel arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF          = 36;
    localparam int DATA_W_DEF          = 256;
    localparam int MAX_OUTSTANDING_DEF = 8;

    // Requester identifier; one bit is enough for two requesters.
    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    // AR arbitration states: IDLE picks a winner, LOCKED holds it until accepted.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // AR payload as seen on every read-address port of this block.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } ar_payload_t;

    // R payload as seen on every read-data port of this block.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } r_payload_t;

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // requester the priority pointer names.
    function automatic req_id_t rr_pick(input logic v0, input logic v1, input req_id_t prio);
        req_id_t win;
        if (v0 && v1) begin
            win = prio;
        end else if (v1) begin
            win = REQ1;
        end else begin
            win = REQ0;
        end
        return win;
    endfunction

endpackage

// File: rtl/rd_order_fifo.sv
// In-order ownership FIFO: remembers which requester issued each accepted
// read burst so returning R beats can be routed back in the same order.
module rd_order_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING_DEF
) (
    input  logic    aclk,
    input  logic    areset,
    input  logic    push,
    input  logic    pop,
    input  req_id_t din,
    output req_id_t dout,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a push alongside it is
    // accepted even when the FIFO is full.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Next-state for storage, pointers and occupancy; pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset empties the FIFO immediately.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// 2:1 AXI4 read-channel arbiter: two requesters share one ID-less memory
// read port. AR is granted round-robin with a registered grant; R bursts are
// routed back in order using the ownership FIFO.
module mem_rd_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic              s0_arvalid,
    output logic              s0_arready,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [7:0]        s0_arlen,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,

    input  logic              s1_arvalid,
    output logic              s1_arready,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [7:0]        s1_arlen,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,

    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast
);

    arb_state_e  state_q, state_d;
    req_id_t     winner_q, winner_d;
    req_id_t     prio_q, prio_d;

    ar_payload_t s0_ar, s1_ar, win_ar;
    r_payload_t  m_r, s0_r, s1_r;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    req_id_t     head_id;

    assign s0_ar = '{addr: s0_araddr, len: s0_arlen, size: s0_arsize, burst: s0_arburst};
    assign s1_ar = '{addr: s1_araddr, len: s1_arlen, size: s1_arsize, burst: s1_arburst};
    assign m_r   = '{data: m_rdata, resp: m_rresp, last: m_rlast};

    assign m_araddr  = win_ar.addr;
    assign m_arlen   = win_ar.len;
    assign m_arsize  = win_ar.size;
    assign m_arburst = win_ar.burst;

    assign s0_rdata = s0_r.data;
    assign s0_rresp = s0_r.resp;
    assign s0_rlast = s0_r.last;
    assign s1_rdata = s1_r.data;
    assign s1_rresp = s1_r.resp;
    assign s1_rlast = s1_r.last;

    // AR arbitration next-state and outputs. The grant is only taken while the
    // FIFO has room, and once LOCKED the winner is held so the memory AR
    // channel stays stable until accepted.
    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        prio_d     = prio_q;
        m_arvalid  = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        fifo_push  = 1'b0;
        win_ar     = '0;
        case (state_q)
            ARB_IDLE: begin
                if ((s0_arvalid || s1_arvalid) && !fifo_full) begin
                    winner_d = rr_pick(s0_arvalid, s1_arvalid, prio_q);
                    state_d  = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                m_arvalid = 1'b1;
                if (winner_q == REQ1) begin
                    win_ar     = s1_ar;
                    s1_arready = m_arready;
                end else begin
                    win_ar     = s0_ar;
                    s0_arready = m_arready;
                end
                if (m_arready) begin
                    fifo_push = 1'b1;
                    prio_d    = ~winner_q;
                    state_d   = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Arbitration registers; after reset requester 0 holds priority.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q  <= ARB_IDLE;
            winner_q <= REQ0;
            prio_q   <= REQ0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            prio_q   <= prio_d;
        end
    end

    // R routing: the FIFO head owns the R channel. With no owner the memory
    // sees rready low, so a stray beat stalls instead of being misrouted.
    always_comb begin
        s0_rvalid = 1'b0;
        s1_rvalid = 1'b0;
        s0_r      = '0;
        s1_r      = '0;
        m_rready  = 1'b0;
        if (!fifo_empty) begin
            if (head_id == REQ1) begin
                s1_rvalid = m_rvalid;
                s1_r      = m_r;
                m_rready  = s1_rready;
            end else begin
                s0_rvalid = m_rvalid;
                s0_r      = m_r;
                m_rready  = s0_rready;
            end
        end
    end

    // Ownership moves on only at the end of a burst, so bursts never interleave.
    assign fifo_pop = m_rvalid & m_rready & m_rlast;

    rd_order_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (winner_q),
        .dout   (head_id),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench for mem_rd_arbiter: directed sequences, a table of
// R-routing vectors and a randomized run against an ownership-queue model.
`timescale 1ns/1ps
module tb_mem_rd_arbiter;

    localparam int ADDR_W = 36;
    localparam int DATA_W = 256;
    localparam int MAXO   = 8;

    logic              aclk = 1'b0;
    logic              areset;
    logic              s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
    logic [ADDR_W-1:0] s0_araddr;
    logic [7:0]        s0_arlen;
    logic [2:0]        s0_arsize;
    logic [1:0]        s0_arburst, s0_rresp;
    logic [DATA_W-1:0] s0_rdata;
    logic              s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
    logic [ADDR_W-1:0] s1_araddr;
    logic [7:0]        s1_arlen;
    logic [2:0]        s1_arsize;
    logic [1:0]        s1_arburst, s1_rresp;
    logic [DATA_W-1:0] s1_rdata;
    logic              m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [ADDR_W-1:0] m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst, m_rresp;
    logic [DATA_W-1:0] m_rdata;

    int vectors     = 0;
    int miscompares = 0;

    mem_rd_arbiter #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s0_arvalid (s0_arvalid),
        .s0_arready (s0_arready),
        .s0_araddr  (s0_araddr),
        .s0_arlen   (s0_arlen),
        .s0_arsize  (s0_arsize),
        .s0_arburst (s0_arburst),
        .s0_rvalid  (s0_rvalid),
        .s0_rready  (s0_rready),
        .s0_rdata   (s0_rdata),
        .s0_rresp   (s0_rresp),
        .s0_rlast   (s0_rlast),
        .s1_arvalid (s1_arvalid),
        .s1_arready (s1_arready),
        .s1_araddr  (s1_araddr),
        .s1_arlen   (s1_arlen),
        .s1_arsize  (s1_arsize),
        .s1_arburst (s1_arburst),
        .s1_rvalid  (s1_rvalid),
        .s1_rready  (s1_rready),
        .s1_rdata   (s1_rdata),
        .s1_rresp   (s1_rresp),
        .s1_rlast   (s1_rlast),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_araddr   (m_araddr),
        .m_arlen    (m_arlen),
        .m_arsize   (m_arsize),
        .m_arburst  (m_arburst),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .m_rdata    (m_rdata),
        .m_rresp    (m_rresp),
        .m_rlast    (m_rlast)
    );

    always #5 aclk = ~aclk;

    // Requesters must hold arvalid until accepted; flag the bench if it does not.
    logic pend0_q, pend1_q;
    always @(posedge aclk) begin
        if (areset) begin
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
        end else begin
            assert (!(pend0_q && !s0_arvalid)) else $error("[TB] s0 dropped arvalid before acceptance");
            assert (!(pend1_q && !s1_arvalid)) else $error("[TB] s1 dropped arvalid before acceptance");
            pend0_q <= s0_arvalid && !s0_arready;
            pend1_q <= s1_arvalid && !s1_arready;
        end
    end

    task automatic check_output(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_arvalid = 0; s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0; s0_rready = 0;
        s1_arvalid = 0; s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0; s1_rready = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    // Issue one AR from a requester and wait (bounded) for its acceptance.
    task automatic issue_ar(input bit id, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
        bit done = 0;
        if (id) begin
            s1_arvalid = 1; s1_araddr = addr; s1_arlen = len; s1_arsize = 3'd5; s1_arburst = 2'b01;
        end else begin
            s0_arvalid = 1; s0_araddr = addr; s0_arlen = len; s0_arsize = 3'd5; s0_arburst = 2'b01;
        end
        m_arready = 1;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge aclk);
            if (m_arvalid && (id ? s1_arready : s0_arready)) begin
                check_output("ar_addr", m_araddr, addr);
                check_output("ar_len", m_arlen, len);
                check_output("ar_burst", m_arburst, 2'b01);
                done = 1;
            end
            step();
        end
        check_output("ar_accepted", done, 1);
        if (id) s1_arvalid = 0; else s0_arvalid = 0;
        m_arready = 0;
    endtask

    // Present one R beat from memory and check it lands on the expected owner.
    task automatic send_beat(input bit owner, input bit last, input logic [DATA_W-1:0] data);
        s0_rready = 1; s1_rready = 1;
        m_rvalid = 1; m_rdata = data; m_rlast = last; m_rresp = 2'b00;
        @(negedge aclk);
        check_output("beat_owner_rvalid", owner ? s1_rvalid : s0_rvalid, 1);
        check_output("beat_other_rvalid", owner ? s0_rvalid : s1_rvalid, 0);
        check_output("beat_rdata", owner ? s1_rdata : s0_rdata, data);
        check_output("beat_rlast", owner ? s1_rlast : s0_rlast, last);
        check_output("beat_m_rready", m_rready, 1);
        step();
        m_rvalid = 0; m_rlast = 0;
    endtask

    // With no burst outstanding a memory beat must be stalled and not routed.
    task automatic check_no_owner(input string tag);
        m_rvalid = 1; m_rlast = 1; s0_rready = 1; s1_rready = 1;
        @(negedge aclk);
        check_output({tag, "_m_rready"}, m_rready, 0);
        check_output({tag, "_s0_rvalid"}, s0_rvalid, 0);
        check_output({tag, "_s1_rvalid"}, s1_rvalid, 0);
        step();
        m_rvalid = 0; m_rlast = 0;
    endtask

    typedef struct {
        logic mrv, r0, r1;
        logic exp_s0v, exp_s1v, exp_mrr;
    } route_vec_t;

    route_vec_t route_tbl[6];

    // Apply one routing vector while requester 1 owns the FIFO head.
    task automatic apply_stimulus(input route_vec_t v, input int idx);
        m_rvalid = v.mrv; s0_rready = v.r0; s1_rready = v.r1; m_rlast = 0;
        m_rdata = {8{$urandom}};
        @(negedge aclk);
        check_output($sformatf("tbl%0d_s0_rvalid", idx), s0_rvalid, v.exp_s0v);
        check_output($sformatf("tbl%0d_s1_rvalid", idx), s1_rvalid, v.exp_s1v);
        check_output($sformatf("tbl%0d_m_rready", idx), m_rready, v.exp_mrr);
        check_output($sformatf("tbl%0d_s1_rdata", idx), s1_rdata, m_rdata);
        step();
        m_rvalid = 0;
    endtask

    typedef struct {
        bit id;
        int beats;
    } burst_t;

    // Randomized run: requesters and memory are driven at random; the model is
    // a queue of outstanding bursts plus a round-robin preference bit.
    task automatic run_random(input int cycles);
        burst_t inflight[$];
        bit prio_m = 0, exp_win = 0;
        bit pend0_prev = 0, pend1_prev = 0, marv_prev = 0;
        int cnt_prev = 0;
        bit hs_ar, hs_r, own;
        for (int c = 0; c < cycles; c++) begin
            @(negedge aclk);
            if (m_arvalid && !marv_prev) begin
                check_output("rnd_grant_room", cnt_prev < MAXO, 1);
                exp_win = (pend0_prev && pend1_prev) ? prio_m : pend1_prev;
                check_output("rnd_grant_pending", exp_win ? pend1_prev : pend0_prev, 1);
            end
            if (m_arvalid) begin
                check_output("rnd_ar_addr", m_araddr, exp_win ? s1_araddr : s0_araddr);
                check_output("rnd_ar_len", m_arlen, exp_win ? s1_arlen : s0_arlen);
                check_output("rnd_arready_win", exp_win ? s1_arready : s0_arready, m_arready);
                check_output("rnd_arready_lose", exp_win ? s0_arready : s1_arready, 0);
            end else begin
                check_output("rnd_arready_idle", {s0_arready, s1_arready}, 0);
            end
            hs_r = 0;
            if (inflight.size() > 0) begin
                own = inflight[0].id;
                check_output("rnd_owner_rvalid", own ? s1_rvalid : s0_rvalid, m_rvalid);
                check_output("rnd_other_rvalid", own ? s0_rvalid : s1_rvalid, 0);
                check_output("rnd_m_rready", m_rready, own ? s1_rready : s0_rready);
                if (m_rvalid) begin
                    check_output("rnd_rdata", own ? s1_rdata : s0_rdata, m_rdata);
                    check_output("rnd_rresp", own ? s1_rresp : s0_rresp, m_rresp);
                    check_output("rnd_rlast", own ? s1_rlast : s0_rlast, m_rlast);
                end
                hs_r = m_rvalid && (own ? s1_rready : s0_rready);
            end else begin
                check_output("rnd_empty_m_rready", m_rready, 0);
                check_output("rnd_empty_rvalid", {s0_rvalid, s1_rvalid}, 0);
            end
            hs_ar      = m_arvalid && m_arready;
            pend0_prev = s0_arvalid;
            pend1_prev = s1_arvalid;
            marv_prev  = m_arvalid;
            cnt_prev   = inflight.size();
            step();
            if (hs_r) begin
                inflight[0].beats--;
                if (inflight[0].beats == 0) void'(inflight.pop_front());
            end
            if (hs_ar) begin
                inflight.push_back('{id: exp_win, beats: int'(exp_win ? s1_arlen : s0_arlen) + 1});
                prio_m = ~exp_win;
                if (exp_win) s1_arvalid = 0; else s0_arvalid = 0;
            end
            if (!s0_arvalid && $urandom_range(0, 2) == 0) begin
                s0_arvalid = 1; s0_araddr = ADDR_W'({$urandom, $urandom});
                s0_arlen = 8'($urandom_range(0, 3)); s0_arsize = 3'd5; s0_arburst = 2'b01;
            end
            if (!s1_arvalid && $urandom_range(0, 2) == 0) begin
                s1_arvalid = 1; s1_araddr = ADDR_W'({$urandom, $urandom});
                s1_arlen = 8'($urandom_range(0, 3)); s1_arsize = 3'd5; s1_arburst = 2'b01;
            end
            m_arready = ($urandom_range(0, 3) != 0);
            s0_rready = ($urandom_range(0, 3) != 0);
            s1_rready = ($urandom_range(0, 3) != 0);
            if (m_rvalid && !hs_r) begin
                m_rvalid = 1;
            end else if (inflight.size() > 0 && $urandom_range(0, 3) != 0) begin
                m_rvalid = 1;
                m_rdata  = {8{$urandom}};
                m_rresp  = 2'($urandom_range(0, 3));
                m_rlast  = (inflight[0].beats == 1);
            end else begin
                m_rvalid = 0; m_rlast = 0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int grants;
        bit g;
        route_tbl[0] = '{mrv: 0, r0: 0, r1: 0, exp_s0v: 0, exp_s1v: 0, exp_mrr: 0};
        route_tbl[1] = '{mrv: 1, r0: 0, r1: 0, exp_s0v: 0, exp_s1v: 1, exp_mrr: 0};
        route_tbl[2] = '{mrv: 1, r0: 1, r1: 0, exp_s0v: 0, exp_s1v: 1, exp_mrr: 0};
        route_tbl[3] = '{mrv: 1, r0: 0, r1: 1, exp_s0v: 0, exp_s1v: 1, exp_mrr: 1};
        route_tbl[4] = '{mrv: 1, r0: 1, r1: 1, exp_s0v: 0, exp_s1v: 1, exp_mrr: 1};
        route_tbl[5] = '{mrv: 0, r0: 1, r1: 1, exp_s0v: 0, exp_s1v: 0, exp_mrr: 1};

        // Reset state and stray beat with empty FIFO.
        do_reset();
        @(negedge aclk);
        check_output("rst_m_arvalid", m_arvalid, 0);
        check_output("rst_arready", {s0_arready, s1_arready}, 0);
        check_output("rst_rvalid", {s0_rvalid, s1_rvalid}, 0);
        check_output("rst_m_rready", m_rready, 0);
        check_output("rst_m_araddr", m_araddr, 0);
        step();
        check_no_owner("rst_stray");

        // Single read of four beats to requester 0.
        issue_ar(0, 36'h1000, 8'd3);
        for (int i = 0; i < 4; i++) send_beat(0, i == 3, DATA_W'(256'hA0 + i));
        check_no_owner("single_drained");

        // Table-driven R routing with requester 1 owning the head.
        issue_ar(1, 36'h2000, 8'd0);
        for (int i = 0; i < 6; i++) apply_stimulus(route_tbl[i], i);
        send_beat(1, 1, DATA_W'(256'hB1));
        check_no_owner("table_drained");

        // Contention: both requesting every cycle alternates s0, s1, s0, s1.
        do_reset();
        s0_arvalid = 1; s0_araddr = 36'hA00; s0_arlen = 0; s0_arsize = 3'd5; s0_arburst = 2'b01;
        s1_arvalid = 1; s1_araddr = 36'hB00; s1_arlen = 0; s1_arsize = 3'd5; s1_arburst = 2'b01;
        m_arready = 1;
        grants = 0;
        for (int i = 0; i < 20 && grants < 4; i++) begin
            @(negedge aclk);
            if (m_arvalid && m_arready) begin
                g = s1_arready;
                check_output($sformatf("rr_grant%0d", grants), g, grants % 2);
                check_output($sformatf("rr_addr%0d", grants), m_araddr, (grants % 2) ? 36'hB00 : 36'hA00);
                grants++;
            end
            step();
        end
        check_output("rr_grant_count", grants, 4);

        // In-order return: one beat to s1 then eight beats to s0.
        do_reset();
        issue_ar(1, 36'h3000, 8'd0);
        issue_ar(0, 36'h4000, 8'd7);
        send_beat(1, 1, DATA_W'(256'hC0));
        for (int i = 0; i < 8; i++) send_beat(0, i == 7, DATA_W'(256'hD0 + i));
        check_no_owner("inorder_drained");

        // Backpressure: eight outstanding bursts fill the FIFO.
        do_reset();
        for (int i = 0; i < MAXO; i++) issue_ar(0, ADDR_W'(36'h5000 + i * 64), 8'd0);
        s0_arvalid = 1; s0_araddr = 36'h5F00; s0_arlen = 0; m_arready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            check_output("full_s0_arready", s0_arready, 0);
            check_output("full_m_arvalid", m_arvalid, 0);
            step();
        end
        m_rvalid = 1; m_rlast = 1; s0_rready = 1;
        @(negedge aclk);
        check_output("full_pop_m_rready", m_rready, 1);
        check_output("full_pop_arready", s0_arready, 0);
        step();
        m_rvalid = 0; m_rlast = 0;
        @(negedge aclk);
        check_output("full_after_pop_arvalid", m_arvalid, 0);
        step();
        @(negedge aclk);
        check_output("full_ninth_arready", s0_arready, 1);
        check_output("full_ninth_addr", m_araddr, 36'h5F00);
        step();
        s0_arvalid = 0; m_arready = 0;

        // AR stall: winner s1 held stable, s0 cannot preempt.
        do_reset();
        s1_arvalid = 1; s1_araddr = 36'h6000; s1_arlen = 8'd1; s1_arsize = 3'd5; s1_arburst = 2'b01;
        @(negedge aclk);
        check_output("stall_latency_arvalid", m_arvalid, 0);
        step();
        s0_arvalid = 1; s0_araddr = 36'h7000; s0_arlen = 0; s0_arsize = 3'd5; s0_arburst = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check_output("stall_m_arvalid", m_arvalid, 1);
            check_output("stall_m_araddr", m_araddr, 36'h6000);
            check_output("stall_arready", {s0_arready, s1_arready}, 0);
            step();
        end
        m_arready = 1;
        @(negedge aclk);
        check_output("stall_s1_accept", s1_arready, 1);
        check_output("stall_s0_blocked", s0_arready, 0);
        step();
        s1_arvalid = 0;
        @(negedge aclk);
        check_output("stall_rearb_gap", m_arvalid, 0);
        step();
        @(negedge aclk);
        check_output("stall_s0_accept", s0_arready, 1);
        check_output("stall_s0_addr", m_araddr, 36'h7000);
        step();
        s0_arvalid = 0; m_arready = 0;

        // R stall: owner rready low mid-burst holds the memory beat.
        send_beat(1, 0, DATA_W'(256'hE0));
        s1_rready = 0; s0_rready = 1; m_rvalid = 1; m_rdata = DATA_W'(256'hE1); m_rlast = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check_output("rstall_m_rready", m_rready, 0);
            check_output("rstall_s1_rvalid", s1_rvalid, 1);
            check_output("rstall_s1_rdata", s1_rdata, DATA_W'(256'hE1));
            check_output("rstall_s0_rvalid", s0_rvalid, 0);
            step();
        end
        s1_rready = 1;
        @(negedge aclk);
        check_output("rstall_release", m_rready, 1);
        step();
        m_rvalid = 0; m_rlast = 0;
        send_beat(0, 1, DATA_W'(256'hE2));
        check_no_owner("rstall_drained");

        // Reset in the middle of an eight-beat burst.
        do_reset();
        issue_ar(0, 36'h8000, 8'd7);
        send_beat(0, 0, DATA_W'(256'hF0));
        m_rvalid = 1; m_rdata = DATA_W'(256'hF1); s0_rready = 1;
        #2 areset = 1'b1;
        @(negedge aclk);
        check_output("midrst_rvalid", {s0_rvalid, s1_rvalid}, 0);
        check_output("midrst_m_arvalid", m_arvalid, 0);
        check_output("midrst_m_rready", m_rready, 0);
        m_rvalid = 0;
        step();
        areset = 1'b0;
        issue_ar(0, 36'h9000, 8'd1);
        send_beat(0, 0, DATA_W'(256'h91));
        send_beat(0, 1, DATA_W'(256'h92));
        check_no_owner("midrst_drained");

        // Randomized traffic against the model.
        do_reset();
        run_random(2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
